// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM states, default sizing
// and a behavioural round-robin pick helper.
package mux_arb_pkg;

  localparam int N_DEF        = 8;
  localparam int SEL_W_DEF    = 3;
  localparam int MAX_HOLD_DEF = 16;

  // Widest request vector rr_pick() accepts; callers zero-extend narrower vectors.
  localparam int RR_MAX_N = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of req scanning upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input int unsigned         ptr,
                                       input int unsigned         n);
    rr_pick_t res;
    int unsigned j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = RR_MAX_N - 1; i >= 0; i--) begin
      if (i < int'(n)) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (req[j]) begin
          res.found = 1'b1;
          res.idx   = 8'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between requester logic and the arbiter; sel goes on to mux_8.sel.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (output req, input grant, input sel, input busy);
  modport slave  (input req, output grant, output sel, output busy);

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, take the lowest
// set bit, then rotate the offset back into an absolute requester index.
module rr_priority_pick
  import mux_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Modular SEL_W-bit arithmetic lands in 0..N-1 once N is subtracted on wrap.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [SEL_W-1:0] src;
    assign src     = (int'(ptr_i) + gi >= N) ? ptr_i + SEL_W'(gi) - SEL_W'(N)
                                             : ptr_i + SEL_W'(gi);
    assign rot[gi] = req_i[src];
  end

  always_comb begin
    valid_o = 1'b0;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid_o = 1'b1;
        off     = SEL_W'(i);
      end
    end
  end

  assign idx_o = (int'(ptr_i) + int'(off) >= N) ? ptr_i + off - SEL_W'(N)
                                                : ptr_i + off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one mux_8 among N requesters; grants are bounded by
// MAX_HOLD cycles and every release is followed by one idle turnaround cycle.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [N-1:0]      ONE_HOT0 = N'(1);

  if (N < 2) begin : g_bad_n
    $error("mux_rr_arbiter: N must be at least 2");
  end
  if ((2 ** SEL_W) < N) begin : g_bad_sel_w
    $error("mux_rr_arbiter: SEL_W too narrow for N");
  end

  arb_state_e        state_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      grant_q;
  logic [SEL_W-1:0]  sel_q;
  logic              busy_q;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              release_now;

  rr_priority_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // A drop and a timeout in the same cycle collapse into one release.
  always_comb begin
    release_now = !bus.req[sel_q];
    if (MAX_HOLD != 0 && hold_q >= HOLD_LIM) release_now = 1'b1;
    ptr_d  = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);
    hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= ONE_HOT0 << pick_idx;
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            hold_q  <= HOLD_W'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            hold_q  <= hold_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: instance A uses MAX_HOLD=16, instance B MAX_HOLD=4.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int N     = 8;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N), .SEL_W(SEL_W)) a_if ();
  mux_rr_arbiter_if #(.N(N), .SEL_W(SEL_W)) b_if ();

  mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    a_if.req = '0;
    b_if.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*(N+SEL_W+1)-1:0] obs;
    a_if.req = '0;
    b_if.req = '0;
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      obs = {a_if.grant, a_if.sel, a_if.busy, b_if.grant, b_if.sel, b_if.busy};
      checks++;
      $display("reset c=%0d rst=%0b grant_a=%h grant_b=%h", c, rst, a_if.grant, b_if.grant);
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%h want=0", c, obs);
      end
    end
  endtask

  task automatic test_single();
    logic [N+SEL_W:0] obs, exp;
    a_if.req = 8'b0010_0000;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 5) a_if.req = '0;
      exp = (c <= 5) ? {8'b0010_0000, 3'd5, 1'b1} : {8'h00, 3'd5, 1'b0};
      obs = {a_if.grant, a_if.sel, a_if.busy};
      checks++;
      $display("single c=%0d grant=%b sel=%0d busy=%0b", c, a_if.grant, a_if.sel, a_if.busy);
      if (obs !== exp) begin
        errors++;
        $display("FAIL single c=%0d got=%h want=%h", c, obs, exp);
      end
    end
  endtask

  // Follows test_single, so the pointer starts at 6.
  task automatic test_wrap_skip();
    logic [7:0] rq [5] = '{8'h05, 8'h04, 8'h04, 8'h00, 8'h00};
    logic [7:0] eg [5] = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h00};
    logic [2:0] es [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
    logic [N+SEL_W:0] obs, exp;
    for (int s = 0; s < 5; s++) begin
      a_if.req = rq[s];
      tick();
      exp = {eg[s], es[s], (eg[s] != 8'h00)};
      obs = {a_if.grant, a_if.sel, a_if.busy};
      checks++;
      $display("wrap s=%0d req=%b grant=%b sel=%0d", s, rq[s], a_if.grant, a_if.sel);
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap_skip s=%0d got=%h want=%h", s, obs, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N+SEL_W:0] obs, exp;
    int k;
    pulse_reset();
    a_if.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      k = g % N;
      tick();
      exp = {ONE_HOT(k), 3'(k), 1'b1};
      obs = {a_if.grant, a_if.sel, a_if.busy};
      checks++;
      $display("rr g=%0d grant=%b sel=%0d", g, a_if.grant, a_if.sel);
      if (obs !== exp) begin
        errors++;
        $display("FAIL rr_grant g=%0d got=%h want=%h", g, obs, exp);
      end
      a_if.req[k] = 1'b0;
      tick();
      exp = {8'h00, 3'(k), 1'b0};
      obs = {a_if.grant, a_if.sel, a_if.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rr_idle g=%0d got=%h want=%h", g, obs, exp);
      end
      a_if.req = 8'hFF;
    end
    a_if.req = '0;
    tick();
    tick();
  endtask

  function automatic logic [N-1:0] ONE_HOT(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic test_timeout();
    logic [7:0] eg [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                            8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
    logic [2:0] es [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                            3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [N+SEL_W:0] obs, exp;
    pulse_reset();
    b_if.req = 8'b0000_0011;
    for (int c = 0; c < 11; c++) begin
      tick();
      exp = {eg[c], es[c], (eg[c] != 8'h00)};
      obs = {b_if.grant, b_if.sel, b_if.busy};
      checks++;
      $display("timeout c=%0d grant=%b sel=%0d", c, b_if.grant, b_if.sel);
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout c=%0d got=%h want=%h", c, obs, exp);
      end
    end
    b_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rq [8] = '{8'h01, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'hFF, 8'h00};
    logic       rr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] eg [8] = '{8'h01, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h01, 8'h00};
    logic [2:0] es [8] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [N+SEL_W:0] obs, exp;
    pulse_reset();
    for (int s = 0; s < 8; s++) begin
      a_if.req = rq[s];
      rst = rr[s];
      tick();
      exp = {eg[s], es[s], (eg[s] != 8'h00)};
      obs = {a_if.grant, a_if.sel, a_if.busy};
      checks++;
      $display("rst_mid s=%0d rst=%0b req=%b grant=%b sel=%0d", s, rst, rq[s], a_if.grant, a_if.sel);
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid s=%0d got=%h want=%h", s, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  // Drop on the MAX_HOLD cycle must advance the pointer once: next grant is 1, not 2.
  task automatic test_drop_at_timeout();
    logic [7:0] rq [7] = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h06, 8'h06, 8'h00};
    logic [7:0] eg [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00};
    logic [2:0] es [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [N+SEL_W:0] obs, exp;
    pulse_reset();
    for (int s = 0; s < 7; s++) begin
      b_if.req = rq[s];
      tick();
      exp = {eg[s], es[s], (eg[s] != 8'h00)};
      obs = {b_if.grant, b_if.sel, b_if.busy};
      checks++;
      $display("drop_to s=%0d req=%b grant=%b sel=%0d", s, rq[s], b_if.grant, b_if.sel);
      if (obs !== exp) begin
        errors++;
        $display("FAIL drop_timeout s=%0d got=%h want=%h", s, obs, exp);
      end
    end
  endtask

  initial begin
    a_if.req = '0;
    b_if.req = '0;
    test_reset();
    test_single();
    test_wrap_skip();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_drop_at_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
